// File: rtl/input_event_pkg.sv
// Shared types and constants for the joystick input event logger.
package input_event_pkg;

    localparam int unsigned PLAYER_W = 3;
    localparam int unsigned BTN_W    = 32;
    localparam int unsigned STAMP_W  = 33;
    localparam logic [7:0]  DROP_MAX = 8'hFF;

    // One logged joystick change; 'stamp' holds the hps_io timestamp
    typedef struct packed {
        logic [PLAYER_W-1:0] player;
        logic [BTN_W-1:0]    buttons;
        logic [STAMP_W-1:0]  stamp;
    } input_event_t;

endpackage

// File: rtl/input_event_capture_if.sv
// Read-side bus of the event FIFO: show-ahead head entry plus pop request.
interface input_event_capture_if #(
    parameter int unsigned TS_W = 33
);
    import input_event_pkg::*;

    logic                rd_en;
    logic                rd_valid;
    logic [PLAYER_W-1:0] rd_player;
    logic [BTN_W-1:0]    rd_buttons;
    logic [TS_W-1:0]     rd_time;

    modport master (
        input  rd_en,
        output rd_valid, rd_player, rd_buttons, rd_time
    );

    modport slave (
        output rd_en,
        input  rd_valid, rd_player, rd_buttons, rd_time
    );

endinterface

// File: rtl/input_event_fifo.sv
// Synchronous show-ahead FIFO of input events with a registered head entry.
module input_event_fifo
    import input_event_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  input_event_t             din,
    input  logic                     pop,
    output input_event_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     valid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    input_event_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;
    logic [CW-1:0]  count_nxt;

    // Accepted push/pop; a full FIFO still takes a push when a pop frees the slot
    always_comb begin
        do_pop    = pop & valid & ~clear;
        do_push   = push & ~clear & (~full | do_pop);
        count_nxt = count + CW'(do_push) - CW'(do_pop);
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
            head   <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            valid <= (count_nxt != '0);
            if (do_pop) begin
                if (count > CW'(1)) begin
                    head <= mem[rd_ptr + AW'(1)];
                end else if (do_push) begin
                    head <= din;
                end
            end else if (do_push && (count == '0)) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/input_event_capture.sv
// Joystick change logger: round-robin scan of PLAYERS words, one event per
// cycle into a show-ahead FIFO, with sticky overflow and a saturating drop count.
// Optional macro INPUT_EVENT_MASK_EN adds player_mask to exclude players from the scan.
module input_event_capture
    import input_event_pkg::*;
#(
    parameter int unsigned PLAYERS = 6,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TS_W    = 33
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic [PLAYERS*32-1:0]    joystick,
    input  logic [TS_W-1:0]          timestamp,
    input  logic                     clear,
`ifdef INPUT_EVENT_MASK_EN
    input  logic [PLAYERS-1:0]       player_mask,
`endif
    input_event_capture_if.master    rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int unsigned PW = PLAYER_W;

    logic [BTN_W-1:0]   captured [PLAYERS];
    logic               primed;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      ptr_nxt;
    logic [PLAYERS-1:0] scan_en;
    logic [PLAYERS-1:0] changed;
    logic               found;
    logic [PW-1:0]      sel;
    int unsigned        idx;
    input_event_t       evt;
    input_event_t       head;
    logic               push;
    logic               drop;
    logic               fifo_full;
    logic               fifo_valid;

`ifdef INPUT_EVENT_MASK_EN
    assign scan_en = player_mask;
`else
    assign scan_en = '1;
`endif

    // Per-player change flags against the last captured word
    always_comb begin
        changed = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            changed[p] = scan_en[p] & (joystick[p*BTN_W +: BTN_W] != captured[p]);
        end
    end

    // Round-robin pick of the first changed player at or after ptr
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int unsigned k = 0; k < PLAYERS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= PLAYERS) begin
                idx = idx - PLAYERS;
            end
            if (!found && changed[PW'(idx)]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        ptr_nxt = (32'(sel) == PLAYERS - 1) ? '0 : sel + PW'(1);
        evt     = '{player:  sel,
                    buttons: joystick[32'(sel)*BTN_W +: BTN_W],
                    stamp:   STAMP_W'(timestamp)};
        push    = primed & found & ~clear;
        drop    = push & fifo_full & ~(rd.rd_en & fifo_valid);
    end

    // Captured words, priming flag and scan pointer
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed <= 1'b0;
            ptr    <= '0;
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                captured[p] <= '0;
            end
        end else if (clear) begin
            primed <= 1'b0;
        end else if (!primed) begin
            primed <= 1'b1;
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                captured[p] <= joystick[p*BTN_W +: BTN_W];
            end
        end else begin
            // Unscanned players keep tracking so re-enabling them is silent
            for (int unsigned p = 0; p < PLAYERS; p++) begin
                if (!scan_en[p]) begin
                    captured[p] <= joystick[p*BTN_W +: BTN_W];
                end
            end
            if (found) begin
                captured[sel] <= joystick[32'(sel)*BTN_W +: BTN_W];
                ptr           <= ptr_nxt;
            end
        end
    end

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    input_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .clear (clear),
        .push  (push),
        .din   (evt),
        .pop   (rd.rd_en),
        .head  (head),
        .count (count),
        .full  (fifo_full),
        .valid (fifo_valid)
    );

    assign rd.rd_valid   = fifo_valid;
    assign rd.rd_player  = head.player;
    assign rd.rd_buttons = head.buttons;
    assign rd.rd_time    = TS_W'(head.stamp);

endmodule

// File: tb/tb_input_event_capture.sv
// Bench for input_event_capture: directed vectors, hand sequences for FIFO
// corner cases, then random stimulus against a queue-based reference model.
module tb_input_event_capture;
    import input_event_pkg::*;

    localparam int unsigned PLAYERS = 6;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TS_W    = 33;
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [PLAYERS*32-1:0] joy;
    logic [TS_W-1:0]       ts;
    logic                  clr;
    logic [PLAYERS-1:0]    mask;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic [7:0]            drop_count;

    input_event_capture_if #(.TS_W(TS_W)) rd_if ();

    input_event_capture #(
        .PLAYERS (PLAYERS),
        .DEPTH   (DEPTH),
        .TS_W    (TS_W)
    ) dut (
        .clk_sys     (clk),
        .reset_n     (rst_n),
        .joystick    (joy),
        .timestamp   (ts),
        .clear       (clr),
`ifdef INPUT_EVENT_MASK_EN
        .player_mask (mask),
`endif
        .rd          (rd_if),
        .count       (count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: event queue plus last-logged word per player
    input_event_t mq [$];
    logic [31:0]  m_cap [PLAYERS];
    bit           m_primed;
    int           m_ptr;
    bit           m_ovf;
    int           m_drops;

    typedef struct {
        logic [7:0]  chg;
        logic [31:0] val;
        bit          rd;
        bit          exp_valid;
        int          exp_cnt;
        int          exp_p;
        logic [31:0] exp_b;
        int          exp_t;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_primed = 0;
        m_ptr    = 0;
        m_ovf    = 0;
        m_drops  = 0;
    endtask

    // Advance the model by one clock using the inputs applied this cycle
    task automatic model_step();
        int sel;
        int p;
        bit pop;
        sel = -1;
        pop = rd_if.rd_en && (mq.size() > 0);
        if (clr) begin
            mq.delete();
            m_ovf    = 0;
            m_drops  = 0;
            m_primed = 0;
            return;
        end
        if (!m_primed) begin
            for (int i = 0; i < PLAYERS; i++) m_cap[i] = joy[i*32 +: 32];
            m_primed = 1;
            return;
        end
        for (int k = 0; k < PLAYERS; k++) begin
            p = (m_ptr + k) % PLAYERS;
            if (sel < 0 && mask[p] && joy[p*32 +: 32] != m_cap[p]) sel = p;
        end
        for (int i = 0; i < PLAYERS; i++) if (!mask[i]) m_cap[i] = joy[i*32 +: 32];
        if (pop) void'(mq.pop_front());
        if (sel >= 0) begin
            m_cap[sel] = joy[sel*32 +: 32];
            m_ptr = (sel + 1) % PLAYERS;
            if (mq.size() < DEPTH) mq.push_back('{player: 3'(sel), buttons: joy[sel*32 +: 32], stamp: ts});
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
    endtask

    task automatic check_model();
        chk("model_status", {rd_if.rd_valid, 32'(count), overflow, drop_count},
            {mq.size() != 0, 32'(mq.size()), m_ovf, 8'(m_drops)});
        if (mq.size() > 0)
            chk("model_head", {rd_if.rd_player, rd_if.rd_buttons, rd_if.rd_time},
                {mq[0].player, mq[0].buttons, mq[0].stamp});
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        ts = ts + 1;
        check_model();
    endtask

    initial begin
        int n;
        int p;
        int rdpct;

        joy = '0;
        joy[31:0] = 32'h10;
        ts = '0;
        clr = 1'b0;
        mask = '1;
        rd_if.rd_en = 1'b0;
        model_reset();

        // 1: reset state and silent priming
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rd_if.rd_valid, 32'(count), overflow, drop_count, rd_if.rd_buttons}, '0);
        rst_n = 1'b1;
        repeat (10) step();
        chk("prime_no_event", {rd_if.rd_valid, 32'(count)}, '0);

        // 2: single change, show-ahead head with timestamp, then pop
        ts = 33'd100;
        joy[31:0] = 32'h1;
        step();
        chk("single_head", {rd_if.rd_valid, 32'(count), rd_if.rd_player, rd_if.rd_buttons, rd_if.rd_time},
            {1'b1, 32'd1, 3'd0, 32'h1, 33'd100});
        rd_if.rd_en = 1'b1;
        step();
        rd_if.rd_en = 1'b0;
        chk("single_pop", {rd_if.rd_valid, 32'(count)}, '0);

        // Bring ptr back to 0 by logging the last player
        joy[5*32 +: 32] = 32'h55;
        step();
        rd_if.rd_en = 1'b1;
        step();
        rd_if.rd_en = 1'b0;

        // 3: simultaneous changes on 1, 3, 5 serialized in order
        tv[0] = '{8'b0010_1010, 32'hA0, 0, 1, 1, 1, 32'hA1, 200};
        tv[1] = '{8'h00, 32'h0, 0, 1, 2, 1, 32'hA1, 200};
        tv[2] = '{8'h00, 32'h0, 0, 1, 3, 1, 32'hA1, 200};
        tv[3] = '{8'h00, 32'h0, 1, 1, 2, 3, 32'hA3, 201};
        tv[4] = '{8'h00, 32'h0, 1, 1, 1, 5, 32'hA5, 202};
        tv[5] = '{8'h00, 32'h0, 1, 0, 0, 0, 32'h0, 0};
        ts = 33'd200;
        for (int i = 0; i < 6; i++) begin
            for (int q = 0; q < PLAYERS; q++)
                if (tv[i].chg[q]) joy[q*32 +: 32] = tv[i].val + 32'(q);
            rd_if.rd_en = tv[i].rd;
            step();
            rd_if.rd_en = 1'b0;
            chk($sformatf("vec%0d_status", i), {rd_if.rd_valid, 32'(count)},
                {tv[i].exp_valid, 32'(tv[i].exp_cnt)});
            if (tv[i].exp_valid)
                chk($sformatf("vec%0d_head", i), {rd_if.rd_player, rd_if.rd_buttons, rd_if.rd_time},
                    {3'(tv[i].exp_p), tv[i].exp_b, 33'(tv[i].exp_t)});
        end

        // 4: 17 changes into a 16-deep FIFO, then drain in order
        for (int i = 0; i < 17; i++) begin
            joy[31:0] = 32'h1000 + 32'(i);
            step();
        end
        chk("overflow_state", {32'(count), overflow, drop_count}, {32'd16, 1'b1, 8'd1});
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), rd_if.rd_buttons, 32'h1000 + 32'(i));
            rd_if.rd_en = 1'b1;
            step();
        end
        rd_if.rd_en = 1'b0;
        chk("drained", {rd_if.rd_valid, 32'(count), overflow}, {1'b0, 32'd0, 1'b1});

        // 5: full FIFO, pop and push in the same cycle
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            joy[31:0] = 32'h2000 + 32'(i);
            step();
        end
        chk("full16", {32'(count), overflow}, {32'd16, 1'b0});
        joy[2*32 +: 32] = 32'h2222;
        rd_if.rd_en = 1'b1;
        step();
        chk("full_pop_push", {32'(count), overflow, drop_count}, {32'd16, 1'b0, 8'd0});
        repeat (15) step();
        rd_if.rd_en = 1'b0;
        chk("last_is_p2", {32'(count), rd_if.rd_player, rd_if.rd_buttons}, {32'd1, 3'd2, 32'h2222});
        rd_if.rd_en = 1'b1;
        step();
        rd_if.rd_en = 1'b0;

        // 6: clear with five entries and a pending change
        for (int i = 0; i < 5; i++) begin
            joy[31:0] = 32'h3000 + 32'(i);
            step();
        end
        chk("five_held", 32'(count), 32'd5);
        joy[3*32 +: 32] = 32'h3333;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clear_flush", {rd_if.rd_valid, 32'(count), overflow, drop_count}, '0);
        repeat (2) step();
        chk("clear_no_event", {rd_if.rd_valid, 32'(count)}, '0);

`ifdef INPUT_EVENT_MASK_EN
        // Masked player changes are absorbed silently, unmask produces nothing stale
        mask[4] = 1'b0;
        joy[4*32 +: 32] = joy[4*32 +: 32] ^ 32'hF;
        repeat (3) step();
        chk("masked_no_event", 32'(count), 32'd0);
        mask[4] = 1'b1;
        repeat (3) step();
        chk("unmask_no_event", 32'(count), 32'd0);
        joy[4*32 +: 32] = joy[4*32 +: 32] ^ 32'h1;
        step();
        chk("unmasked_event", {32'(count), rd_if.rd_player}, {32'd1, 3'd4});
        rd_if.rd_en = 1'b1;
        step();
        rd_if.rd_en = 1'b0;
`endif

        // Random stimulus against the model, with one mid-run async reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_reset", {rd_if.rd_valid, 32'(count), overflow, drop_count}, '0);
                @(posedge clk);
                #1 rst_n = 1'b1;
                model_reset();
            end
            case ((c / 250) % 3)
                0: rdpct = 20;
                1: rdpct = 50;
                default: rdpct = 90;
            endcase
            if ($urandom_range(99) < 30) begin
                n = $urandom_range(3, 1);
                for (int j = 0; j < n; j++) begin
                    p = $urandom_range(PLAYERS - 1);
                    joy[p*32 +: 32] = joy[p*32 +: 32] ^ (32'd1 << $urandom_range(31));
                end
            end
            rd_if.rd_en = ($urandom_range(99) < rdpct);
            clr = ($urandom_range(299) == 0);
`ifdef INPUT_EVENT_MASK_EN
            if ($urandom_range(49) == 0) mask = PLAYERS'($urandom);
`endif
            step();
        end
        clr = 1'b0;
        rd_if.rd_en = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
